// File: rtl/fpu_addsub_sched.sv
// fpu_addsub_sched: issue scheduler and 3-entry result buffer for the shared
// single-precision FP add/sub datapath. Two requesters (0 = execute stage,
// 1 = iterative FP unit) share one datapath with a single internal pipeline
// register; results come back one cycle after issue and are buffered so that
// response backpressure never drops data.
//
// Optional feature macro: FPU_ADDSUB_RR_EN
//   defined   -> round-robin arbitration between the two requesters
//   undefined -> fixed priority, requester 0 always wins
//
// Handshake: an operation transfers on a requester port in any cycle where
// reqN_valid_i and reqN_ready_o are both 1. A result transfers on the
// response port in any cycle where rsp_valid_o and rsp_ready_i are both 1.
// reqN_ready_o never depends on rsp_ready_i; it is derived only from the
// valids, flush_i, rst_n and registered state.
module fpu_addsub_sched #(
    parameter int TAGW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [31:0]     req0_rs1_i,
    input  logic [31:0]     req0_rs2_i,
    input  logic            req0_sub_i,
    input  logic [TAGW-1:0] req0_tag_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [31:0]     req1_rs1_i,
    input  logic [31:0]     req1_rs2_i,
    input  logic            req1_sub_i,
    input  logic [TAGW-1:0] req1_tag_i,
    input  logic            flush_i,
    output logic [31:0]     dp_rs1_o,
    output logic [31:0]     dp_rs2_o,
    output logic            dp_sub_o,
    input  logic [34:0]     dp_c_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [34:0]     rsp_c_o,
    output logic            rsp_src_o,
    output logic [TAGW-1:0] rsp_tag_o,
    output logic            busy_o
);

    // Result FIFO storage and bookkeeping
    logic [34:0]     mem_c   [0:2];
    logic            mem_src [0:2];
    logic [TAGW-1:0] mem_tag [0:2];
    logic [1:0]      wr_ptr;
    logic [1:0]      rd_ptr;
    logic [1:0]      cnt;

    // Operation currently held in the datapath's pipeline register
    logic            inflight_v;
    logic            inflight_src;
    logic [TAGW-1:0] inflight_tag;

    logic            issue_ok;
    logic            pick1;
    logic            gnt0;
    logic            gnt1;
    logic            push;
    logic            pop;

    // Pointers wrap 2 -> 0 for the 3-entry buffer
    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue only if the result plus everything already owed still fits the FIFO
    assign issue_ok = rst_n & ~flush_i &
                      (({1'b0, cnt} + {2'b00, inflight_v}) <= 3'd2);

`ifdef FPU_ADDSUB_RR_EN
    // Last granted requester; reset value 1 hands the first contended grant to 0
    logic last_grant;

    // Round-robin pointer moves only when a grant is made
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end

    assign pick1 = req1_valid_i & (~req0_valid_i | ~last_grant);
`else
    assign pick1 = req1_valid_i & ~req0_valid_i;
`endif

    assign gnt1         = issue_ok & pick1;
    assign gnt0         = issue_ok & req0_valid_i & ~pick1;
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // Drive the granted operands into the datapath, zeros when idle
    always_comb begin
        dp_rs1_o = 32'd0;
        dp_rs2_o = 32'd0;
        dp_sub_o = 1'b0;
        if (gnt0) begin
            dp_rs1_o = req0_rs1_i;
            dp_rs2_o = req0_rs2_i;
            dp_sub_o = req0_sub_i;
        end else if (gnt1) begin
            dp_rs1_o = req1_rs1_i;
            dp_rs2_o = req1_rs2_i;
            dp_sub_o = req1_sub_i;
        end
    end

    // Track which operation the datapath register is holding next cycle
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            inflight_v   <= 1'b0;
            inflight_src <= 1'b0;
            inflight_tag <= '0;
        end else begin
            inflight_v <= gnt0 | gnt1;
            if (gnt0 | gnt1) begin
                inflight_src <= gnt1;
                inflight_tag <= gnt1 ? req1_tag_i : req0_tag_i;
            end
        end
    end

    assign push = inflight_v;
    assign pop  = rsp_valid_o & rsp_ready_i;

    // FIFO pointers and occupancy; flush and reset empty it
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      cnt <= cnt + 2'd1;
            else if (pop && !push) cnt <= cnt - 2'd1;
        end
    end

    // FIFO payload storage; contents are meaningless unless counted by cnt
    always_ff @(posedge clk) begin
        if (push) begin
            mem_c[wr_ptr]   <= dp_c_i;
            mem_src[wr_ptr] <= inflight_src;
            mem_tag[wr_ptr] <= inflight_tag;
        end
    end

    // Head is presented from storage and forced to zero while empty
    assign rsp_valid_o = (cnt != 2'd0);
    assign rsp_c_o     = rsp_valid_o ? mem_c[rd_ptr]   : 35'd0;
    assign rsp_src_o   = rsp_valid_o ? mem_src[rd_ptr] : 1'b0;
    assign rsp_tag_o   = rsp_valid_o ? mem_tag[rd_ptr] : '0;
    assign busy_o      = inflight_v | rsp_valid_o;

endmodule

// File: doc/fpu_addsub_sched.md
# fpu_addsub_sched

Issue scheduler and result buffer for the shared single-precision FP add/sub datapath. Arbitrates two requesters, requester 0 being the execute stage and requester 1 the iterative FP unit, onto the one add/sub datapath. Tracks the operation held in the datapath's internal pipeline register, and buffers the unrounded 35-bit results so that backpressure on the response port never loses data. It sits between the FPU request muxing and the rounding stage.

## Interface
- `TAGW`, default 3: width of the requester-supplied tag returned with each result.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid_i`  in  1  requester 0 has an operation.
- `req0_ready_o`  out  1  requester 0 operation is accepted this cycle.
- `req0_rs1_i`, `req0_rs2_i`  in  32 each  requester 0 operands, IEEE-754 single precision.
- `req0_sub_i`  in  1  requester 0 operation select: 1 = rs1-rs2, 0 = rs1+rs2.
- `req0_tag_i`  in  TAGW  requester 0 tag.
- `req1_*`  same set for requester 1.
- `flush_i`  in  1  discards all in-flight and buffered operations.
- `dp_rs1_o`, `dp_rs2_o`  out  32 each  operands to the datapath.
- `dp_sub_o`  out  1  subtract select to the datapath.
- `dp_c_i`  in  35  datapath result: {sign, 9-bit exponent, 25-bit mantissa+GR}.
- `rsp_valid_o`  out  1  result available.
- `rsp_ready_i`  in  1  consumer takes the result.
- `rsp_c_o`  out  35  result payload, passed unmodified from `dp_c_i`.
- `rsp_src_o`  out  1  originating requester.
- `rsp_tag_o`  out  TAGW  originating tag.
- `busy_o`  out  1  high while any operation is in flight or buffered.

## Operation
- **Issue gate.** Issue is permitted when `cnt + inflight_v <= 2`, `flush_i`=0 and `rst_n`=1.
  - `cnt` is the result-FIFO occupancy, 0..3.
  - `inflight_v` is high while the datapath register holds a live operation.
- **Grant.** A grant goes to at most one valid requester. `reqN_ready_o` is 1 only for the granted requester; it is combinational from the valids and registered state only, never from `rsp_ready_i`.
- **Datapath drive.** On a grant, `dp_*` carry the granted operands and sub bit. With no grant, `dp_*` are all zero.
- **In-flight tracking.** At the end of a grant cycle: `inflight_v`=1 and `inflight_src`/`inflight_tag` are captured. With no grant, `inflight_v`=0.
- **Result capture.** While `inflight_v`=1, `{dp_c_i, inflight_src, inflight_tag}` is pushed into the 3-entry FIFO at the end of the cycle.
- **Response.**
  - `rsp_*` present the FIFO head from registers.
  - Pop occurs on `rsp_valid_o & rsp_ready_i`.
  - A push and a pop in the same cycle leave `cnt` unchanged.
  - Results leave in issue order.
- **Flush.** Flush is synchronous. The following cycle has `inflight_v`=0 and `cnt`=0. No grant occurs in the flush cycle. The arbitration pointer is kept.
- **FIFO.** Read and write pointers are 2 bits and wrap 2→0. `cnt` never exceeds 3, and a push into a full FIFO is impossible by the issue gate. The verification bench asserts this.
- **Stale datapath contents.** The datapath's own register may hold stale data after reset or flush. It is ignored because `inflight_v`=0.

## Timing
- **Latency.** A request accepted in cycle N produces `rsp_valid_o`=1 in cycle N+2.
  - The datapath register loads at the end of N.
  - The FIFO push occurs at the end of N+1.
- **Throughput.** With `rsp_ready_i` held 1, one operation is issued per cycle indefinitely (`cnt` ≤1).
- **Stall.** With `rsp_ready_i`=0, at most 3 further results are accepted, then `reqN_ready_o`=0 until a pop.
- **Reset values.**
  - All ready outputs, `rsp_valid_o` and `busy_o` are 0.
  - `rsp_c_o`, `rsp_src_o`, `rsp_tag_o` and `dp_*` are 0.
  - The arbitration pointer resets to "last grant = 1".
  - Ready outputs are forced 0 while `rst_n`=0.
- **Reset mid-operation.** In-flight and buffered results are dropped. No response appears for them.

## Configuration
- **`FPU_ADDSUB_RR_EN` defined:** round-robin arbitration.
  - When both requesters are valid, the one not granted last wins.
  - The pointer updates only on a grant.
  - The first contended grant after reset goes to requester 0.
- **Undefined:** fixed priority. Requester 0 always wins, and requester 1 is granted only when `req0_valid_i`=0. The pointer logic is not built.

## Test plan
- **Single op.** `req0` 1.0 (0x3F800000) + 2.0 (0x40000000), tag 5, accepted cycle N → cycle N+2: `rsp_valid_o`=1, `rsp_src_o`=0, `rsp_tag_o`=5, `rsp_c_o` equal to the datapath output for that pair.
- **Back-to-back.** 8 consecutive `req1` ops with `rsp_ready_i`=1 → `req1_ready_o` high every cycle; 8 responses on consecutive cycles in order, tags 0..7.
- **Backpressure.** `rsp_ready_i`=0 with `req0` continuously valid → exactly 3 accepts, then `req0_ready_o`=0. Raise `rsp_ready_i` → the 3 results drain in order, and issue resumes the cycle after the first pop.
- **Contention.** Both requesters continuously valid.
  - With `FPU_ADDSUB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: all grants go to 0.
- **Flush.** `flush_i` one cycle after an accept with 2 results buffered → next cycle `rsp_valid_o`=0, `busy_o`=0. No response appears for the flushed tags.
- **Reset.** `rst_n`=0 for one cycle while an op is in flight → all outputs 0 next cycle; no stale response appears afterwards.
